// File: rtl/seg_pipelined_addsub.sv
// Pipelined add/subtract unit: the carry/borrow chain is cut into SEG-bit segments,
// one register stage per segment, with valid/ready flow control and result flags.
module seg_pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  generate
    if (SEG < 1) begin : g_bad_seg
      $fatal(1, "seg_pipelined_addsub: SEG must be at least 1");
    end else if (WIDTH % SEG != 0) begin : g_bad_width
      $fatal(1, "seg_pipelined_addsub: WIDTH must be a multiple of SEG");
    end
  endgenerate

  // Returns {carry_out, sum} for add or {borrow_out, difference} for sub;
  // the extra top bit goes to 1 exactly when the unsigned subtraction wraps.
  function automatic logic [SEG:0] seg_op(input logic [SEG-1:0] x, input logic [SEG-1:0] z,
                                          input logic c, input logic s);
    logic [SEG:0] cx;
    cx = {{SEG{1'b0}}, c};
    if (s) seg_op = {1'b0, x} - {1'b0, z} - cx;
    else   seg_op = {1'b0, x} + {1'b0, z} + cx;
  endfunction

  // Handshake: a beat moves into stage k when stage k is empty or stage k+1 takes
  // its current beat this cycle; the final stage drains on out_ready. Input and
  // output transfers happen on valid && ready at the rising edge.
  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  ra [STAGES];
  logic [WIDTH-1:0]  rb [STAGES];
  logic [WIDTH-1:0]  rr [STAGES];
  logic              rc [STAGES];
  logic              rs [STAGES];
  logic              ovf_q, zero_q;

  logic [STAGES-1:0] acc;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_r [STAGES];
  logic              src_c [STAGES];
  logic              src_s [STAGES];
  logic [STAGES-1:0] src_v;
  logic [SEG:0]      seg_res [STAGES];
  logic [WIDTH-1:0]  nxt_r [STAGES];
  logic              nxt_c [STAGES];
  logic              sa, sb, sy, ovf_n, zero_n;

  always_comb begin : ready_chain
    logic down;
    down = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc[k] = !v[k] || down;
      down   = acc[k];
    end
  end

  always_comb begin : datapath
    src_a[0] = a;
    src_b[0] = b;
    src_r[0] = '0;
    src_c[0] = cin;
    src_s[0] = sub;
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = ra[k-1];
      src_b[k] = rb[k-1];
      src_r[k] = rr[k-1];
      src_c[k] = rc[k-1];
      src_s[k] = rs[k-1];
      src_v[k] = v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_res[k] = seg_op(src_a[k][k*SEG +: SEG], src_b[k][k*SEG +: SEG], src_c[k], src_s[k]);
      nxt_r[k]   = src_r[k];
      nxt_r[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
      nxt_c[k]   = seg_res[k][SEG];
    end
  end

  assign sa     = src_a[LAST][WIDTH-1];
  assign sb     = src_b[LAST][WIDTH-1];
  assign sy     = nxt_r[LAST][WIDTH-1];
  assign ovf_n  = src_s[LAST] ? ((sa != sb) && (sy != sa)) : ((sa == sb) && (sy != sa));
  assign zero_n = ~|nxt_r[LAST];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v      <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        ra[k] <= '0;
        rb[k] <= '0;
        rr[k] <= '0;
        rc[k] <= 1'b0;
        rs[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (acc[k]) begin
          v[k] <= src_v[k];
          // Data only moves with a real beat so an idle output keeps its last value.
          if (src_v[k]) begin
            ra[k] <= src_a[k];
            rb[k] <= src_b[k];
            rr[k] <= nxt_r[k];
            rc[k] <= nxt_c[k];
            rs[k] <= src_s[k];
          end
        end
      end
      if (acc[LAST] && src_v[LAST]) begin
        ovf_q  <= ovf_n;
        zero_q <= zero_n;
      end
    end
  end

  assign in_ready  = rst_n && acc[0];
  assign out_valid = v[LAST];
  assign y         = rr[LAST];
  assign cout      = rc[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seg_pipelined_addsub.sv
// Bench for seg_pipelined_addsub: directed vectors, backpressure, mid-flight reset
// and a random-handshake soak, checked by a scoreboard queue and a monitor process.
module tb_seg_pipelined_addsub;

  localparam int W  = 16;
  localparam int RW = W + 3;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, sub;
  logic         out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a, b, y;

  int           n_tests = 0;
  int           n_fails = 0;
  logic [RW-1:0] exp_q[$];
  logic         soak_on = 1'b0;

  seg_pipelined_addsub #(.WIDTH(W), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .cout(cout), .ovf(ovf), .zero(zero)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [RW-1:0] pack(input logic [W-1:0] ry, input logic rc,
                                         input logic ro, input logic rz);
    return {ry, rc, ro, rz};
  endfunction

  // Full-width reference for the random phases.
  function automatic logic [RW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc, input logic ms);
    logic [W:0] r;
    logic       ov;
    if (ms) begin
      r  = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mc};
      ov = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
    end else begin
      r  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
      ov = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
    end
    return {r[W-1:0], r[W], ov, (r[W-1:0] == '0)};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                      input logic ts, input logic [RW-1:0] e);
    int waited;
    in_valid = 1'b1;
    a = ta; b = tbv; cin = tc; sub = ts;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (in_ready) exp_q.push_back(e);
    else check("in_ready_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      step();
      w++;
    end
    repeat (6) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic [W-1:0]  bp_a [6];
  logic [W-1:0]  bp_b [6];
  logic          bp_s [6];
  logic [RW-1:0] bp_e [6];
  logic [W-1:0]  y_hold;
  logic [RW-1:0] got_e;
  int            idx;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;

    fork
      // monitor / scoreboard
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(out_valid), 32'd0);
          end else begin
            got_e = exp_q.pop_front();
            check("result", 32'({y, cout, ovf, zero}), 32'(got_e));
          end
        end
      end
      forever begin
        @(posedge clk);
        #1;
        if (soak_on) out_ready = ($urandom_range(0, 3) != 0);
      end
      begin
        #800000;
        $display("FAIL watchdog: time limit reached, %0d results outstanding", exp_q.size());
        $fatal(1, "watchdog");
      end
    join_none

    // reset state, with in_valid held high to show in_ready stays low
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_y", 32'(y), 32'd0);
    check("reset_flags", 32'({cout, ovf, zero}), 32'd0);
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;

    // first op: latency and single-cycle out_valid
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, pack(16'h0100, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("latency_edge_t+%0d", i), 32'(out_valid), 32'(i == 3));
    end
    step();

    // directed vectors, back to back
    send(16'h0005, 16'h0007, 1'b0, 1'b1, pack(16'hFFFE, 1'b1, 1'b0, 1'b0));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, pack(16'h7FFF, 1'b0, 1'b1, 1'b0));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, pack(16'h8000, 1'b0, 1'b1, 1'b0));
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, pack(16'h0000, 1'b1, 1'b0, 1'b1));
    send(16'h1234, 16'h1233, 1'b1, 1'b1, pack(16'h0000, 1'b0, 1'b0, 1'b1));
    send(16'h0000, 16'h0001, 1'b0, 1'b1, pack(16'hFFFF, 1'b1, 1'b0, 1'b0));
    drain();

    // backpressure: six ops offered while the output is stalled
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 16'h1111 * 16'(i + 1);
      bp_b[i] = 16'h0F0F + 16'(i * 3);
      bp_s[i] = i[0];
      bp_e[i] = model(bp_a[i], bp_b[i], 1'b0, bp_s[i]);
    end
    out_ready = 1'b0;
    idx = 0;
    cin = 1'b0;
    repeat (8) begin
      in_valid = 1'b1;
      a = bp_a[idx]; b = bp_b[idx]; sub = bp_s[idx];
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(bp_e[idx]);
        idx++;
      end
      step();
    end
    check("bp_accepted", 32'(idx), 32'd4);
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    y_hold = y;
    check("bp_hold_y_first", 32'(y_hold), 32'(bp_e[0][RW-1:3]));
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_y", 32'(y), 32'(y_hold));
    end
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("bp_stream_%0d", i), 32'(out_valid), 32'd1);
      if (in_ready && idx < 6) begin
        exp_q.push_back(bp_e[idx]);
        idx++;
      end
      step();
      if (idx < 6) begin
        a = bp_a[idx]; b = bp_b[idx]; sub = bp_s[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    check("bp_all_accepted", 32'(idx), 32'd6);
    drain();

    // reset with three ops in flight: none of them may ever appear
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 16'h4000 + 16'(i); b = 16'h0100; cin = 1'b0; sub = 1'b0;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_low", 32'(in_ready), 32'd0);
    step();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    send(16'h0002, 16'h0003, 1'b0, 1'b0, pack(16'h0005, 1'b0, 1'b0, 1'b0));
    drain();

    // soak: random operands, random input gaps and output stalls
    soak_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] ra_v, rb_v;
      logic         rc_v, rs_v;
      ra_v = 16'($urandom);
      rb_v = 16'($urandom);
      rc_v = 1'($urandom_range(0, 1));
      rs_v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        step();
      end
      send(ra_v, rb_v, rc_v, rs_v, model(ra_v, rb_v, rc_v, rs_v));
    end
    soak_on = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
